servo_udar_ctrl: RTL and testbench

SERVO_UDAR_CTRL -- requirements
Module: servo_udar_ctrl

---
 rtl/servo_udar_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_servo_udar_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_udar_ctrl.sv
// Multi-channel servo PWM generator with a byte-command parser and an
// ultrasonic ranger whose 16-bit result is returned as two bytes.
module servo_udar_ctrl #(
    parameter int SERVO_CH   = 2,
    parameter int PWM_PERIOD = 1000000,
    parameter int POS_UNIT   = 500,
    parameter int POS_MIN    = 50,
    parameter int POS_MAX    = 250,
    parameter int POS_RST    = 150,
    parameter int TRIG_LEN   = 500,
    parameter int ECHO_DIV   = 2900,
    parameter int ECHO_MAX   = 1900000,
    parameter int BYTE_TO    = 100000
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_busy,
    output logic [SERVO_CH-1:0] servo,
    output logic                trig,
    input  logic                cap_sig
);

    localparam int CNT_W   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int PROD_W  = 8 + $clog2(POS_UNIT + 1);
    localparam int CMP_W   = (CNT_W > PROD_W) ? CNT_W : PROD_W;
    localparam int TMR_MAX = (ECHO_MAX > TRIG_LEN) ? ECHO_MAX : TRIG_LEN;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TO_W    = $clog2(BYTE_TO + 1);
    localparam int DIV_W   = $clog2(ECHO_DIV + 1);

    localparam logic [7:0] P_MIN = 8'(POS_MIN);
    localparam logic [7:0] P_MAX = 8'(POS_MAX);
    localparam logic [7:0] P_RST = 8'(POS_RST);

    typedef enum logic [2:0] {
        IDLE, ARG, TRIG, WAIT_RISE, MEASURE, SEND_HI, SEND_LO
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   pwm_cnt;
    logic [7:0]         pos_sto [SERVO_CH];
    logic [7:0]         pos_act [SERVO_CH];
    logic [7:0]         pos_stg [SERVO_CH];
    logic [CMP_W-1:0]   thr     [SERVO_CH];
    logic [7:0]         cmd, chan;
    logic [4:0]         arg_idx;
    logic [TO_W-1:0]    to_cnt;
    logic [TMR_W-1:0]   tmr;
    logic [DIV_W-1:0]   presc;
    logic [15:0]        result;
    logic               sync1, sync2;

    logic echo, to_hit, idle_like, start_cmd, arg_acc, last_arg;
    logic trig_done, echo_to, range_to, tx_fire;

    function automatic logic [7:0] clamp_pos(input logic [7:0] p);
        if (p < P_MIN) return P_MIN;
        if (p > P_MAX) return P_MAX;
        return p;
    endfunction

    // 0xFFFF is reserved for "no echo", so a long echo stops one short of it
    function automatic logic [15:0] sat_inc(input logic [15:0] r);
        return (r >= 16'hFFFE) ? 16'hFFFE : r + 16'd1;
    endfunction

    assign echo      = sync2;
    assign to_hit    = (to_cnt >= TO_W'(BYTE_TO));
    // A stale partial command behaves exactly like IDLE, including for a byte that lands on the timeout
    assign idle_like = (state == IDLE) || ((state == ARG) && to_hit);
    assign start_cmd = idle_like && rx_valid && ((rx_data == 8'h03) || (rx_data == 8'h04));
    assign arg_acc   = (state == ARG) && !to_hit && rx_valid;
    assign last_arg  = (cmd == 8'h03) ? (arg_idx == 5'(SERVO_CH - 1)) : (arg_idx == 5'd1);
    assign trig_done = (tmr == TMR_W'(TRIG_LEN - 1));
    assign echo_to   = (tmr >= TMR_W'(ECHO_MAX - 1));
    assign range_to  = echo_to && ((state == WAIT_RISE) || ((state == MEASURE) && echo));

    always_comb begin
        for (int i = 0; i < SERVO_CH; i++) begin
            thr[i] = CMP_W'(pos_act[i]) * CMP_W'(POS_UNIT);
        end
    end

    always_comb begin
        state_n = state;
        tx_fire = 1'b0;
        case (state)
            IDLE, ARG: begin
                if (idle_like) begin
                    state_n = IDLE;
                    if (rx_valid) begin
                        case (rx_data)
                            8'h03, 8'h04: state_n = ARG;
                            8'h0C:        state_n = TRIG;
                            default:      state_n = IDLE;
                        endcase
                    end
                end else if (arg_acc && last_arg) begin
                    state_n = IDLE;
                end
            end
            TRIG:      if (trig_done) state_n = WAIT_RISE;
            WAIT_RISE: begin
                if (range_to)  state_n = SEND_HI;
                else if (echo) state_n = MEASURE;
            end
            MEASURE:   if (!echo || range_to) state_n = SEND_HI;
            SEND_HI: begin
                if (!tx_busy) begin
                    tx_fire = 1'b1;
                    state_n = SEND_LO;
                end
            end
            // tx_valid still high means the MSB went out last cycle: leave a gap
            SEND_LO: begin
                if (!tx_busy && !tx_valid) begin
                    tx_fire = 1'b1;
                    state_n = IDLE;
                end
            end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            pwm_cnt  <= '0;
            servo    <= '0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            trig     <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            to_cnt   <= '0;
            tmr      <= '0;
            for (int i = 0; i < SERVO_CH; i++) begin
                pos_sto[i] <= P_RST;
                pos_act[i] <= P_RST;
            end
        end else begin
            sync1 <= cap_sig;
            sync2 <= sync1;
            // New positions take effect only on the frame boundary
            if (pwm_cnt == CNT_W'(PWM_PERIOD - 1)) begin
                pwm_cnt <= '0;
                for (int i = 0; i < SERVO_CH; i++) pos_act[i] <= pos_sto[i];
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            for (int i = 0; i < SERVO_CH; i++) begin
                servo[i] <= (CMP_W'(pwm_cnt) < thr[i]);
            end
            if (arg_acc && last_arg) begin
                for (int i = 0; i < SERVO_CH; i++) begin
                    if (cmd == 8'h03) begin
                        pos_sto[i] <= (i == SERVO_CH - 1) ? clamp_pos(rx_data) : pos_stg[i];
                    end else if (chan == 8'(i)) begin
                        pos_sto[i] <= clamp_pos(rx_data);
                    end
                end
            end
            trig     <= (state_n == TRIG);
            tx_valid <= tx_fire;
            if (tx_fire) tx_data <= (state == SEND_HI) ? result[15:8] : result[7:0];
            if (start_cmd || arg_acc) to_cnt <= '0;
            else if (!to_hit)         to_cnt <= to_cnt + 1'b1;
            // Restart on entering and on leaving TRIG; the echo timeout runs from trig falling
            if ((state == TRIG) != (state_n == TRIG)) tmr <= '0;
            else                                      tmr <= tmr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start_cmd) begin
            cmd     <= rx_data;
            arg_idx <= '0;
        end else if (arg_acc) begin
            arg_idx <= arg_idx + 1'b1;
            if (cmd == 8'h03) begin
                for (int i = 0; i < SERVO_CH; i++) begin
                    if (arg_idx == 5'(i)) pos_stg[i] <= clamp_pos(rx_data);
                end
            end else if (arg_idx == 5'd0) begin
                chan <= rx_data;
            end
        end
        if (state == TRIG) begin
            presc  <= '0;
            result <= '0;
        end else if (range_to) begin
            result <= 16'hFFFF;
        end else if (((state == WAIT_RISE) || (state == MEASURE)) && echo) begin
            if (presc == DIV_W'(ECHO_DIV - 1)) begin
                presc  <= '0;
                result <= sat_inc(result);
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_servo_udar_ctrl.sv
// Directed bench for servo_udar_ctrl with scaled-down timing parameters:
// a vector table for position commands plus hand sequences for ranging.
module tb_servo_udar_ctrl;

    localparam int CH   = 2;
    localparam int PER  = 2000;
    localparam int UNIT = 4;
    localparam int TLEN = 10;
    localparam int DIV  = 29;
    localparam int EMAX = 5000;
    localparam int BTO  = 300;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_busy;
    logic [CH-1:0] servo;
    logic          trig;
    logic          cap_sig;

    int n_cmp = 0;
    int n_bad = 0;

    servo_udar_ctrl #(
        .SERVO_CH(CH), .PWM_PERIOD(PER), .POS_UNIT(UNIT),
        .POS_MIN(50), .POS_MAX(250), .POS_RST(150),
        .TRIG_LEN(TLEN), .ECHO_DIV(DIV), .ECHO_MAX(EMAX), .BYTE_TO(BTO)
    ) dut (
        .clk(clk), .rst_i(rst_i),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
        .servo(servo), .trig(trig), .cap_sig(cap_sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        int         e0, e1;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_rise(output bit found, output bit aligned);
        bit p0, p1;
        found   = 1'b0;
        aligned = 1'b0;
        @(negedge clk);
        p0 = servo[0];
        p1 = servo[1];
        for (int n = 0; n < 3 * PER; n++) begin
            @(negedge clk);
            if (servo[0] && !p0) begin
                found   = 1'b1;
                aligned = servo[1] && !p1;
                break;
            end
            p0 = servo[0];
            p1 = servo[1];
        end
    endtask

    task automatic check_frame(input string name, input int e0, input int e1);
        bit found, aligned;
        int h0, h1;
        wait_rise(found, aligned);
        h0 = -1;
        h1 = -1;
        if (found) begin
            h0 = int'(servo[0]);
            h1 = int'(servo[1]);
            for (int c = 1; c < PER; c++) begin
                @(negedge clk);
                h0 += int'(servo[0]);
                h1 += int'(servo[1]);
            end
        end
        check({name, "_ch0_high"}, h0, e0);
        check({name, "_ch1_high"}, h1, e1);
        check({name, "_aligned"}, int'(aligned), 1);
    endtask

    // Issue 0x0C with the strobe visible to the loop, return the trig width seen
    task automatic start_ranging(output int th);
        th = 0;
        @(negedge clk);
        rx_data  = 8'h0C;
        rx_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
            if (trig) th++;
            else if (th > 0) break;
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, expected run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   found, aligned;
        int   h0, h1, th, c, pulses, bad;
        logic [7:0] q [$];
        longint b0, b1;

        tbl[0] = '{b0: 8'h03, b1: 8'd150, b2: 8'd200, nb: 3, e0: 600,  e1: 800};
        tbl[1] = '{b0: 8'h04, b1: 8'd5,   b2: 8'd100, nb: 3, e0: 600,  e1: 800};
        tbl[2] = '{b0: 8'h04, b1: 8'd1,   b2: 8'd40,  nb: 3, e0: 600,  e1: 200};
        tbl[3] = '{b0: 8'h04, b1: 8'd0,   b2: 8'd255, nb: 3, e0: 1000, e1: 200};
        tbl[4] = '{b0: 8'h55, b1: 8'd0,   b2: 8'd0,   nb: 1, e0: 1000, e1: 200};
        tbl[5] = '{b0: 8'h03, b1: 8'd10,  b2: 8'd250, nb: 3, e0: 200,  e1: 1000};

        rst_i    = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_busy  = 1'b0;
        cap_sig  = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_servo", servo, 0);
        check("rst_trig", trig, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        rst_i = 1'b0;

        check_frame("default", 600, 600);

        for (int i = 0; i < 6; i++) begin
            send_byte(tbl[i].b0);
            if (tbl[i].nb > 1) send_byte(tbl[i].b1);
            if (tbl[i].nb > 2) send_byte(tbl[i].b2);
            check_frame($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1);
        end

        // Command lands early in a frame: that frame keeps 50/250
        wait_rise(found, aligned);
        check("mid_found", int'(found), 1);
        h0 = int'(servo[0]);
        h1 = int'(servo[1]);
        for (int k = 1; k < PER; k++) begin
            @(negedge clk);
            case (k)
                10: begin rx_data = 8'h03;  rx_valid = 1'b1; end
                12: begin rx_data = 8'd150; rx_valid = 1'b1; end
                14: begin rx_data = 8'd200; rx_valid = 1'b1; end
                default: rx_valid = 1'b0;
            endcase
            h0 += int'(servo[0]);
            h1 += int'(servo[1]);
        end
        check("mid_cur_ch0", h0, 200);
        check("mid_cur_ch1", h1, 1000);
        check_frame("mid_next", 600, 800);

        // Ranging: 2910 echo clocks / 29 = 100 cm; a 0x03 sent meanwhile is dropped
        start_ranging(th);
        check("trig_width", th, TLEN);
        repeat (50) @(negedge clk);
        send_byte(8'h03);
        send_byte(8'd200);
        send_byte(8'd250);
        cap_sig = 1'b1;
        pulses = 0;
        for (int k = 0; k < 2910; k++) begin
            @(negedge clk);
            if (tx_valid) pulses++;
        end
        cap_sig = 1'b0;
        check("tx_during_echo", pulses, 0);
        q.delete();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid) q.push_back(tx_data);
        end
        b0 = (q.size() > 0) ? longint'(q[0]) : -1;
        b1 = (q.size() > 1) ? longint'(q[1]) : -1;
        check("range_tx_count", q.size(), 2);
        check("range_msb", b0, 8'h00);
        check("range_lsb", b1, 8'h64);
        check_frame("after_range", 600, 800);

        // No echo: timeout result, LSB held back by tx_busy
        start_ranging(th);
        check("trig_width2", th, TLEN);
        c = 0;
        found = 1'b0;
        for (int k = 0; k < EMAX + 1000; k++) begin
            @(negedge clk);
            c++;
            if (tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        tx_busy = 1'b1;
        check("to_msb_seen", int'(found), 1);
        check("to_latency_ok", int'(c >= EMAX && c <= EMAX + 3), 1);
        check("to_msb", tx_data, 8'hFF);
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tx_valid) pulses++;
        end
        check("busy_holds_lsb", pulses, 0);
        tx_busy = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("to_lsb_seen", int'(found), 1);
        check("to_lsb", tx_data, 8'hFF);

        // Byte timeout: partial 0x03 dropped, late 200 ignored in IDLE
        send_byte(8'h03);
        send_byte(8'd100);
        repeat (BTO + 150) @(negedge clk);
        send_byte(8'd200);
        check_frame("byte_timeout", 600, 800);

        // Reset during MEASURE aborts ranging and restores reset positions
        start_ranging(th);
        repeat (20) @(negedge clk);
        cap_sig = 1'b1;
        repeat (300) @(negedge clk);
        rst_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (trig || tx_valid || servo != 0) bad++;
        end
        check("rst_mid_outputs", bad, 0);
        rst_i = 1'b0;
        repeat (50) @(negedge clk);
        cap_sig = 1'b0;
        pulses = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_valid || trig) pulses++;
        end
        check("rst_mid_no_tx", pulses, 0);
        check_frame("after_rst", 600, 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
